// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: takes a pattern/len/reps/gap command and
// streams it MSB-first, one bit per bit_en strobe, with optional idle gaps.
module seq_pattern_tx #(
  parameter int   PAT_W      = 5,
  parameter int   LEN_W      = 3,
  parameter int   GAP_W      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [PAT_W-1:0] cmd_pattern,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       cmd_reps,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             bit_en,
  input  logic             abort,
  output logic             dataout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  state_t           r_state, w_state_next;
  logic [PAT_W-1:0] r_pat, w_pat_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic [GAP_W-1:0] r_gap, w_gap_next;
  logic [LEN_W-1:0] r_idx, w_idx_next;
  logic [7:0]       r_frames, w_frames_next;
  logic [GAP_W-1:0] r_gcnt, w_gcnt_next;
  logic             r_dataout, w_dataout_next;
  logic             r_dout_valid, w_dout_valid_next;
  logic             r_frame_start, w_frame_start_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;

  logic [LEN_W-1:0] w_len_eff, w_len_m1, w_rlen_m1, w_idx_m1;
  logic [7:0]       w_reps_eff;
  logic [PAT_W-1:0] w_cmd_sh, w_first_sh, w_next_sh;

  assign w_len_eff  = (cmd_len == '0 || cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign w_len_m1   = w_len_eff - 1'b1;
  assign w_rlen_m1  = r_len - 1'b1;
  assign w_idx_m1   = r_idx - 1'b1;
  assign w_reps_eff = (cmd_reps == 8'd0) ? 8'd1 : cmd_reps;

  // Variable bit selects done by shifting so any PAT_W/LEN_W pairing stays width-clean.
  assign w_cmd_sh   = cmd_pattern >> w_len_m1;
  assign w_first_sh = r_pat >> w_rlen_m1;
  assign w_next_sh  = r_pat >> w_idx_m1;

  assign cmd_ready   = (r_state == S_IDLE);
  assign dataout     = r_dataout;
  assign dout_valid  = r_dout_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;
  assign done        = r_done;

  always_comb begin
    w_state_next       = r_state;
    w_pat_next         = r_pat;
    w_len_next         = r_len;
    w_gap_next         = r_gap;
    w_idx_next         = r_idx;
    w_frames_next      = r_frames;
    w_gcnt_next        = r_gcnt;
    w_dataout_next     = r_dataout;
    w_dout_valid_next  = r_dout_valid;
    w_frame_start_next = 1'b0;
    w_busy_next        = r_busy;
    w_done_next        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_pat_next         = cmd_pattern;
          w_len_next         = w_len_eff;
          w_gap_next         = cmd_gap;
          w_idx_next         = w_len_m1;
          w_frames_next      = w_reps_eff;
          w_dataout_next     = w_cmd_sh[0];
          w_dout_valid_next  = 1'b1;
          w_frame_start_next = 1'b1;
          w_busy_next        = 1'b1;
          w_state_next       = S_SEND;
        end
      end
      S_SEND: begin
        if (bit_en) begin
          if (r_idx != '0) begin
            w_idx_next     = w_idx_m1;
            w_dataout_next = w_next_sh[0];
          end else if (r_frames > 8'd1) begin
            w_frames_next = r_frames - 8'd1;
            if (r_gap != '0) begin
              w_state_next      = S_GAP;
              w_dataout_next    = IDLE_LEVEL;
              w_dout_valid_next = 1'b0;
              w_gcnt_next       = r_gap;
            end else begin
              w_idx_next         = w_rlen_m1;
              w_dataout_next     = w_first_sh[0];
              w_frame_start_next = 1'b1;
            end
          end else begin
            w_state_next      = S_IDLE;
            w_busy_next       = 1'b0;
            w_dout_valid_next = 1'b0;
            w_dataout_next    = IDLE_LEVEL;
            w_done_next       = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (bit_en) begin
          if (r_gcnt == GAP_W'(1)) begin
            w_state_next       = S_SEND;
            w_idx_next         = w_rlen_m1;
            w_dataout_next     = w_first_sh[0];
            w_frame_start_next = 1'b1;
            w_dout_valid_next  = 1'b1;
          end
          w_gcnt_next = r_gcnt - 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Cancel wins over everything while a transfer is running; no done pulse.
    if (abort && r_busy) begin
      w_state_next       = S_IDLE;
      w_dataout_next     = IDLE_LEVEL;
      w_dout_valid_next  = 1'b0;
      w_frame_start_next = 1'b0;
      w_busy_next        = 1'b0;
      w_done_next        = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pat         <= '0;
      r_len         <= '0;
      r_gap         <= '0;
      r_idx         <= '0;
      r_frames      <= '0;
      r_gcnt        <= '0;
      r_dataout     <= IDLE_LEVEL;
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pat         <= w_pat_next;
      r_len         <= w_len_next;
      r_gap         <= w_gap_next;
      r_idx         <= w_idx_next;
      r_frames      <= w_frames_next;
      r_gcnt        <= w_gcnt_next;
      r_dataout     <= w_dataout_next;
      r_dout_valid  <= w_dout_valid_next;
      r_frame_start <= w_frame_start_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected bits are queued at command
// time and compared as each new serial bit appears on the output.
module tb_seq_pattern_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_pattern;
  logic [2:0] cmd_len;
  logic [7:0] cmd_reps;
  logic [3:0] cmd_gap;
  logic       bit_en;
  logic       abort;
  logic       dataout, dout_valid, frame_start, busy, done;

  seq_pattern_tx dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pattern(cmd_pattern), .cmd_len(cmd_len), .cmd_reps(cmd_reps),
    .cmd_gap(cmd_gap), .bit_en(bit_en), .abort(abort), .dataout(dataout),
    .dout_valid(dout_valid), .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic d; logic fs; } exp_t;
  exp_t q[$];

  int  n_checks = 0;
  int  n_errors = 0;
  int  busy_total = 0, dv_total = 0, done_total = 0;
  bit  mon_on = 1'b0;
  bit  be_mode = 1'b0;
  logic prev_be = 1'b0, prev_dv = 1'b0, last_bit = 1'b0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Must be called just after a rising edge; returns just after the accept edge.
  task automatic send_cmd(input logic [4:0] pat, input logic [2:0] len,
                          input logic [7:0] reps, input logic [3:0] gap);
    int n = 0;
    int l, r;
    while (!cmd_ready && n < 100) begin step(); n++; end
    if (n >= 100) check_eq("cmd_ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_pattern = pat; cmd_len = len; cmd_reps = reps; cmd_gap = gap;
    l = (len == 0 || len > 5) ? 5 : int'(len);
    r = (reps == 0) ? 1 : int'(reps);
    for (int f = 0; f < r; f++)
      for (int i = l - 1; i >= 0; i--)
        q.push_back('{d: pat[i], fs: (i == l - 1)});
    $display("cmd pat=%b len=%0d reps=%0d gap=%0d -> %0d bits", pat, len, reps, gap, l * r);
    step();
    cmd_valid = 1'b0;
    cmd_pattern = 5'($urandom); cmd_len = 3'($urandom); cmd_reps = 8'($urandom); cmd_gap = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clock); n++; end
    if (n >= 500) check_eq("busy_timeout", 1, 0);
    step();
    check_eq("queue_drained", q.size(), 0);
  endtask

  initial begin
    bit_en = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bit_en = be_mode ? ~bit_en : 1'b1;
    end
  end

  // Output monitor: a new bit is one with frame_start, or one following an enabled edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        if (busy) busy_total++;
        if (dout_valid) dv_total++;
        if (done) done_total++;
        if (dout_valid && (frame_start || (prev_be && prev_dv))) begin
          if (q.size() == 0) check_eq("unexpected_bit", 1, 0);
          else begin
            e = q.pop_front();
            check_eq("bit_data", dataout, e.d);
            check_eq("bit_frame_start", frame_start, e.fs);
            last_bit = dataout;
          end
        end else if (dout_valid) begin
          check_eq("bit_hold", dataout, last_bit);
          check_eq("fs_on_hold", frame_start, 0);
        end else begin
          check_eq("idle_level", dataout, 0);
        end
      end
      prev_be = bit_en;
      prev_dv = dout_valid;
    end
  end

  initial begin
    int b0, v0, d0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_pattern = '0; cmd_len = '0;
    cmd_reps = '0; cmd_gap = '0; abort = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("rst_dataout", dataout, 0);
    check_eq("rst_dout_valid", dout_valid, 0);
    check_eq("rst_frame_start", frame_start, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    mon_on = 1'b1;
    step();

    // 1: single frame with exact cycle positions
    d0 = done_total;
    send_cmd(5'b11101, 3'd5, 8'd1, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check_eq($sformatf("t1_dv_c%0d", k), dout_valid, 1);
      check_eq($sformatf("t1_busy_c%0d", k), busy, 1);
    end
    @(negedge clock);
    check_eq("t1_done_c6", done, 1);
    check_eq("t1_ready_c6", cmd_ready, 1);
    check_eq("t1_dv_c6", dout_valid, 0);
    @(negedge clock);
    check_eq("t1_done_c7", done, 0);
    wait_idle();
    check_eq("t1_done_count", done_total - d0, 1);

    // 2: back-to-back overlap frames
    b0 = busy_total; v0 = dv_total; d0 = done_total;
    send_cmd(5'b11101, 3'd5, 8'd3, 4'd0);
    wait_idle();
    check_eq("t2_busy_cycles", busy_total - b0, 15);
    check_eq("t2_dv_cycles", dv_total - v0, 15);
    check_eq("t2_done_count", done_total - d0, 1);

    // 3: gapped repeat
    b0 = busy_total; v0 = dv_total; d0 = done_total;
    send_cmd(5'b11101, 3'd5, 8'd2, 4'd3);
    wait_idle();
    check_eq("t3_busy_cycles", busy_total - b0, 13);
    check_eq("t3_dv_cycles", dv_total - v0, 10);
    check_eq("t3_done_count", done_total - d0, 1);

    // 4: half-rate strobe
    be_mode = 1'b1;
    step();
    v0 = dv_total; d0 = done_total;
    send_cmd(5'b11101, 3'd5, 8'd1, 4'd0);
    wait_idle();
    be_mode = 1'b0;
    step();
    check_eq("t4_dv_held", int'((dv_total - v0) >= 9 && (dv_total - v0) <= 10), 1);
    check_eq("t4_done_count", done_total - d0, 1);

    // 5a: abort during bit 3 of a two-frame transfer
    d0 = done_total;
    send_cmd(5'b11101, 3'd5, 8'd2, 4'd0);
    repeat (3) @(posedge clock);
    #1 abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clock);
    check_eq("t5a_busy", busy, 0);
    check_eq("t5a_dv", dout_valid, 0);
    check_eq("t5a_dataout", dataout, 0);
    check_eq("t5a_done", done, 0);
    check_eq("t5a_ready", cmd_ready, 1);
    check_eq("t5a_bits_left", q.size(), 6);
    q.delete();
    repeat (3) @(negedge clock);
    check_eq("t5a_no_done", done_total - d0, 0);
    step();

    // 5b: reset at the same point, then an immediate new command
    d0 = done_total;
    send_cmd(5'b11101, 3'd5, 8'd2, 4'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t5b_busy", busy, 0);
    check_eq("t5b_dv", dout_valid, 0);
    check_eq("t5b_ready", cmd_ready, 1);
    check_eq("t5b_bits_left", q.size(), 6);
    q.delete();
    send_cmd(5'b10011, 3'd5, 8'd1, 4'd0);
    @(negedge clock);
    check_eq("t5b_accept_fs", frame_start, 1);
    wait_idle();
    check_eq("t5b_done_count", done_total - d0, 1);

    // 6: edge commands
    v0 = dv_total;
    send_cmd(5'b10110, 3'd0, 8'd1, 4'd0);
    wait_idle();
    check_eq("t6_len0_bits", dv_total - v0, 5);
    v0 = dv_total;
    send_cmd(5'b10110, 3'd7, 8'd1, 4'd0);
    wait_idle();
    check_eq("t6_len7_bits", dv_total - v0, 5);
    v0 = dv_total; d0 = done_total;
    send_cmd(5'b10011, 3'd5, 8'd0, 4'd0);
    wait_idle();
    check_eq("t6_reps0_bits", dv_total - v0, 5);
    check_eq("t6_reps0_done", done_total - d0, 1);
    b0 = busy_total; d0 = done_total;
    send_cmd(5'b11001, 3'd5, 8'd1, 4'd2);
    step();
    check_eq("t6_ready_busy", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_pattern = 5'b00110; cmd_len = 3'd3; cmd_reps = 8'd4;
    step();
    cmd_valid = 1'b0;
    wait_idle();
    repeat (10) step();
    check_eq("t6_drop_busy", busy_total - b0, 5);
    check_eq("t6_drop_done", done_total - d0, 1);
    check_eq("t6_drop_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
